// File: rtl/if_bus_if_if.sv
// Purpose : shared instruction-bus signal bundle between the fetch interface and the bus arbiter/memory.
// Latency : none, wires only.
// Backpressure: request/grant for ownership, bus_rdy marks the data beat.
//
// Signals:
//   bus_req      master -> slave  bus request
//   bus_grnt     slave  -> master bus grant
//   bus_addr     master -> slave  word address
//   bus_as       master -> slave  address strobe, one-cycle pulse
//   bus_rw       master -> slave  1 = read
//   bus_rd_data  slave  -> master read data
//   bus_rdy      slave  -> master read data valid this cycle
interface if_bus_if_if #(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32
);
    logic              bus_req;
    logic              bus_grnt;
    logic [ADDR_W-1:0] bus_addr;
    logic              bus_as;
    logic              bus_rw;
    logic [DATA_W-1:0] bus_rd_data;
    logic              bus_rdy;

    modport master (
        output bus_req, bus_addr, bus_as, bus_rw,
        input  bus_grnt, bus_rd_data, bus_rdy
    );

    modport slave (
        input  bus_req, bus_addr, bus_as, bus_rw,
        output bus_grnt, bus_rd_data, bus_rdy
    );
endinterface

// File: rtl/if_bus_if.sv
// Purpose : instruction-fetch bus master feeding the IF pipeline register (one read per fetch).
// Latency : best case 2 cycles from req_en to data (grant next cycle, rdy in first access cycle).
// Backpressure: busy stalls the pipeline until the word arrives; bus side waits on bus_grnt and bus_rdy.
//
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   addr         word address to fetch (captured on leaving IDLE)
//   req_en       a fetch is wanted this cycle
//   stall/flush  pipeline control inputs
//   rd_data      instruction word to the IF register (combinational)
//   busy         stall request to pipeline control (combinational)
//   bus          master side of the instruction bus
module if_bus_if #(
    parameter int                ADDR_W   = 30,
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] NOP_INSN = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic              req_en,
    input  logic              stall,
    input  logic              flush,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    if_bus_if_if.master       bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        ACCESS = 2'd2,
        STALL  = 2'd3
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] hold_q;
    logic              flush_pend;
    logic              bus_req_q;
    logic              bus_as_q;
    logic [ADDR_W-1:0] bus_addr_q;

    assign bus.bus_req  = bus_req_q;
    assign bus.bus_as   = bus_as_q;
    assign bus.bus_addr = bus_addr_q;
    assign bus.bus_rw   = 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            addr_q     <= '0;
            hold_q     <= NOP_INSN;
            flush_pend <= 1'b0;
            bus_req_q  <= 1'b0;
            bus_as_q   <= 1'b0;
            bus_addr_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_en && !flush) begin
                        addr_q    <= addr;
                        bus_req_q <= 1'b1;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    // Flush before the grant is taken: nothing reached the bus yet.
                    if (flush) begin
                        bus_req_q <= 1'b0;
                        state     <= IDLE;
                    end else if (bus.bus_grnt) begin
                        bus_addr_q <= addr_q;
                        bus_as_q   <= 1'b1;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    bus_as_q <= 1'b0;
                    if (bus.bus_rdy) begin
                        bus_req_q  <= 1'b0;
                        flush_pend <= 1'b0;
                        // Park the word only when the pipeline will still want it.
                        if (stall && !flush && !flush_pend) begin
                            hold_q <= bus.bus_rd_data;
                            state  <= STALL;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (flush) begin
                        // The bus cycle cannot be aborted; remember to discard its data.
                        flush_pend <= 1'b1;
                    end
                end
                STALL: begin
                    if (!stall || flush) begin
                        hold_q <= NOP_INSN;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        busy = 1'b0;
        case (state)
            IDLE:    busy = req_en && !flush;
            REQ:     busy = 1'b1;
            ACCESS:  busy = !bus.bus_rdy;
            default: busy = 1'b0;
        endcase
    end

    always_comb begin
        rd_data = NOP_INSN;
        if (state == ACCESS && bus.bus_rdy && !flush && !flush_pend) begin
            rd_data = bus.bus_rd_data;
        end else if (state == STALL) begin
            rd_data = hold_q;
        end
    end

endmodule
